// File: rtl/grant_decoder.sv
// Sequential one-hot grant decoder: accepts a binary port index over valid/ready
// and holds a registered one-hot grant until the granted port releases it.
// Optional forced release after TIMEOUT cycles: define GRANT_DECODER_TIMEOUT_EN.
module grant_decoder #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned IW      = (WIDTH > 1 ? $clog2(WIDTH) : 1),
   parameter int unsigned TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IW-1:0]    s_index,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] release_in,
   output logic [WIDTH-1:0] grant,
   output logic             grant_valid,
   output logic [IW-1:0]    grant_encoded,
   output logic             error,
   output logic             timeout
);

   localparam logic [IW:0] WIDTH_W = (IW + 1)'(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] grant_q, grant_d;
   logic             gv_q, gv_d;
   logic [IW-1:0]    enc_q, enc_d;
   logic             err_q, err_d;

   logic             rel_hit_c;
   logic             xfer_c;
   logic             in_range_c;
   logic             expire_c;

`ifdef GRANT_DECODER_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;

   // Last permitted grant cycle: the counter started at 0 on the load.
   assign expire_c = (cnt_q == CW'(TIMEOUT - 1));
`else
   logic unused_timeout_cfg;

   // TIMEOUT only matters when the forced-release logic is built in.
   assign unused_timeout_cfg = (TIMEOUT >= 2);
   assign expire_c           = 1'b0;
`endif

   // The grant is one-hot, so masking by it selects release_in[grant_encoded].
   assign rel_hit_c  = gv_q && (|(release_in & grant_q));
   assign in_range_c = ({1'b0, s_index} < WIDTH_W);
   assign s_ready    = (state_q == IDLE) || rel_hit_c;
   assign xfer_c     = s_valid && s_ready;

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gv_d    = gv_q;
      enc_d   = enc_q;
      err_d   = 1'b0;
`ifdef GRANT_DECODER_TIMEOUT_EN
      cnt_d   = cnt_q;
      to_d    = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (xfer_c) begin
               if (in_range_c) begin
                  state_d = GRANT;
                  grant_d = WIDTH'(1) << s_index;
                  gv_d    = 1'b1;
                  enc_d   = s_index;
`ifdef GRANT_DECODER_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         GRANT: begin
            if (rel_hit_c) begin
               state_d = IDLE;
               grant_d = '0;
               gv_d    = 1'b0;
               enc_d   = '0;
               if (xfer_c && in_range_c) begin
                  state_d = GRANT;
                  grant_d = WIDTH'(1) << s_index;
                  gv_d    = 1'b1;
                  enc_d   = s_index;
`ifdef GRANT_DECODER_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else if (xfer_c) begin
                  err_d = 1'b1;
               end
            end else if (expire_c) begin
               state_d = IDLE;
               grant_d = '0;
               gv_d    = 1'b0;
               enc_d   = '0;
`ifdef GRANT_DECODER_TIMEOUT_EN
               to_d    = 1'b1;
`endif
            end else begin
`ifdef GRANT_DECODER_TIMEOUT_EN
               cnt_d = cnt_q + CW'(1);
`endif
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = '0;
            gv_d    = 1'b0;
            enc_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         gv_q    <= 1'b0;
         enc_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gv_q    <= gv_d;
         enc_q   <= enc_d;
         err_q   <= err_d;
      end
   end

`ifdef GRANT_DECODER_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end

   assign timeout = to_q;
`else
   assign timeout = 1'b0;
`endif

   assign grant         = grant_q;
   assign grant_valid   = gv_q;
   assign grant_encoded = enc_q;
   assign error         = err_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Bench for grant_decoder (WIDTH=5, TIMEOUT=8): directed scenarios plus random
// traffic checked against a cycle-level model of the grant ownership rules.
module tb_grant_decoder;

   localparam int unsigned W  = 5;
   localparam int unsigned IW = 3;
   localparam int unsigned TO = 8;

   logic          clk;
   logic          rst_n;
   logic [IW-1:0] s_index;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  release_in;
   logic [W-1:0]  grant;
   logic          grant_valid;
   logic [IW-1:0] grant_encoded;
   logic          error;
   logic          timeout;

   int vectors     = 0;
   int miscompares = 0;

   // Model: index of current owner (-1 none) and how many cycles it has been visible.
   int   m_idx  = -1;
   int   m_held = 0;
   logic m_err  = 1'b0;
   logic m_to   = 1'b0;
   logic obs_ready;
   logic exp_ready;

   grant_decoder #(.WIDTH(W), .TIMEOUT(TO)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_index      (s_index),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .release_in   (release_in),
      .grant        (grant),
      .grant_valid  (grant_valid),
      .grant_encoded(grant_encoded),
      .error        (error),
      .timeout      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] exp_grant();
      logic [W-1:0] one;
      one = W'(1);
      return (m_idx < 0) ? '0 : (one << m_idx);
   endfunction

   // Drive one cycle of inputs, sample s_ready mid-cycle, advance the model,
   // and return #1 after the clock edge.
   task automatic apply(input logic rst, input logic v, input logic [IW-1:0] idx,
                        input logic [W-1:0] rel);
      logic relhit;
      logic held_limit;
      rst_n      = rst;
      s_valid    = v;
      s_index    = idx;
      release_in = rel;
      #2;
      obs_ready = s_ready;
      exp_ready = (m_idx < 0) ? 1'b1 : rel[m_idx];
      relhit    = (m_idx >= 0) && rel[m_idx];
      m_err     = 1'b0;
      m_to      = 1'b0;
`ifdef GRANT_DECODER_TIMEOUT_EN
      held_limit = (m_held >= int'(TO));
`else
      held_limit = 1'b0;
`endif
      if (!rst) begin
         m_idx  = -1;
         m_held = 0;
      end else if (v && exp_ready) begin
         if (int'(idx) < int'(W)) begin
            m_idx  = int'(idx);
            m_held = 1;
         end else begin
            m_err  = 1'b1;
            m_idx  = -1;
            m_held = 0;
         end
      end else if (relhit) begin
         m_idx  = -1;
         m_held = 0;
      end else if (m_idx >= 0) begin
         if (held_limit) begin
            m_idx  = -1;
            m_held = 0;
            m_to   = 1'b1;
         end else begin
            m_held = m_held + 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      s_valid    = 1'b1;
      s_index    = 3'd2;
      release_in = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      s_valid = 1'b0;
      m_idx = -1; m_held = 0; m_err = 1'b0; m_to = 1'b0;
      #1;
      vectors++;
      if (grant !== '0) begin
         miscompares++; $display("FAIL reset_grant: got %b expected %b", grant, 5'b0);
      end
      vectors++;
      if (grant_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_grant_valid: got %b expected 0", grant_valid);
      end
      vectors++;
      if (grant_encoded !== '0) begin
         miscompares++; $display("FAIL reset_encoded: got %0d expected 0", grant_encoded);
      end
      vectors++;
      if (error !== 1'b0 || timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pulses: got error=%b timeout=%b expected 0 0", error, timeout);
      end
      vectors++;
      if (s_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_ready: got %b expected 1", s_ready);
      end
      #1;
   endtask

   task automatic test_basic_grant();
      apply(1'b1, 1'b1, 3'd2, '0);
      vectors++;
      if (obs_ready !== 1'b1) begin
         miscompares++; $display("FAIL basic_accept_ready: got %b expected 1", obs_ready);
      end
      vectors++;
      if (grant !== 5'b00100 || grant_encoded !== 3'd2 || grant_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_grant: got grant=%b enc=%0d gv=%b expected 00100 2 1",
                  grant, grant_encoded, grant_valid);
      end
      vectors++;
      if (s_ready !== 1'b0) begin
         miscompares++; $display("FAIL basic_busy_ready: got %b expected 0", s_ready);
      end
      apply(1'b1, 1'b0, 3'd0, '0);
      apply(1'b1, 1'b0, 3'd0, '0);
      vectors++;
      if (grant !== 5'b00100) begin
         miscompares++; $display("FAIL basic_hold: got %b expected 00100", grant);
      end
      apply(1'b1, 1'b0, 3'd0, 5'b00100);
      vectors++;
      if (obs_ready !== 1'b1) begin
         miscompares++; $display("FAIL basic_release_ready: got %b expected 1", obs_ready);
      end
      vectors++;
      if (grant !== '0 || grant_valid !== 1'b0 || grant_encoded !== '0) begin
         miscompares++;
         $display("FAIL basic_release: got grant=%b gv=%b enc=%0d expected 0 0 0",
                  grant, grant_valid, grant_encoded);
      end
   endtask

   task automatic test_foreign_release();
      apply(1'b1, 1'b1, 3'd1, '0);
      apply(1'b1, 1'b0, 3'd0, 5'b11101);
      vectors++;
      if (obs_ready !== 1'b0) begin
         miscompares++; $display("FAIL foreign_ready: got %b expected 0", obs_ready);
      end
      vectors++;
      if (grant !== 5'b00010) begin
         miscompares++; $display("FAIL foreign_hold: got %b expected 00010", grant);
      end
      apply(1'b1, 1'b0, 3'd0, 5'b00010);
      vectors++;
      if (grant !== '0) begin
         miscompares++; $display("FAIL foreign_release: got %b expected 0", grant);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] one;
      one = W'(1);
      apply(1'b1, 1'b1, 3'd3, '0);
      apply(1'b1, 1'b0, 3'd0, '0);
      apply(1'b1, 1'b1, 3'd0, 5'b01000);
      vectors++;
      if (grant !== 5'b00001 || grant_encoded !== 3'd0) begin
         miscompares++;
         $display("FAIL b2b_switch: got grant=%b enc=%0d expected 00001 0", grant, grant_encoded);
      end
      // Same index again, then one new grant per cycle across every port.
      apply(1'b1, 1'b1, 3'd0, 5'b00001);
      vectors++;
      if (grant !== 5'b00001 || grant_valid !== 1'b1) begin
         miscompares++; $display("FAIL b2b_regrant: got %b expected 00001", grant);
      end
      for (int i = 1; i < int'(W); i++) begin
         apply(1'b1, 1'b1, IW'(i), one << (i - 1));
         vectors++;
         if (grant !== (one << i) || grant_encoded !== IW'(i)) begin
            miscompares++;
            $display("FAIL b2b_stream: got grant=%b enc=%0d expected %b %0d",
                     grant, grant_encoded, one << i, i);
         end
      end
      apply(1'b1, 1'b0, 3'd0, 5'b10000);
   endtask

   task automatic test_out_of_range();
      apply(1'b1, 1'b1, 3'd6, '0);
      vectors++;
      if (error !== 1'b1 || grant !== '0) begin
         miscompares++;
         $display("FAIL oor_error: got error=%b grant=%b expected 1 00000", error, grant);
      end
      vectors++;
      if (s_ready !== 1'b1) begin
         miscompares++; $display("FAIL oor_ready: got %b expected 1", s_ready);
      end
      apply(1'b1, 1'b0, 3'd0, '0);
      vectors++;
      if (error !== 1'b0) begin
         miscompares++; $display("FAIL oor_pulse_width: got %b expected 0", error);
      end
      // Highest legal index, then release with an illegal index in the same cycle.
      apply(1'b1, 1'b1, 3'd4, '0);
      vectors++;
      if (grant !== 5'b10000 || error !== 1'b0) begin
         miscompares++;
         $display("FAIL oor_top_index: got grant=%b error=%b expected 10000 0", grant, error);
      end
      apply(1'b1, 1'b1, 3'd5, 5'b10000);
      vectors++;
      if (error !== 1'b1 || grant !== '0 || grant_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL oor_release_error: got error=%b grant=%b gv=%b expected 1 0 0",
                  error, grant, grant_valid);
      end
      apply(1'b1, 1'b0, 3'd0, '0);
   endtask

   task automatic test_reset_mid_grant();
      apply(1'b1, 1'b1, 3'd3, '0);
      apply(1'b0, 1'b1, 3'd1, 5'b00000);
      vectors++;
      if (grant !== '0 || grant_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_grant: got grant=%b gv=%b expected 0 0", grant, grant_valid);
      end
      apply(1'b1, 1'b0, 3'd0, '0);
   endtask

   task automatic test_timeout();
`ifdef GRANT_DECODER_TIMEOUT_EN
      int  n;
      logic fr_ready;
      apply(1'b1, 1'b1, 3'd0, '0);
      n = 1;
      fr_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         apply(1'b1, 1'b0, 3'd0, '0);
         if (grant === '0) begin
            fr_ready = obs_ready;
            break;
         end
         n++;
      end
      vectors++;
      if (n != int'(TO)) begin
         miscompares++; $display("FAIL timeout_hold_cycles: got %0d expected %0d", n, TO);
      end
      vectors++;
      if (timeout !== 1'b1) begin
         miscompares++; $display("FAIL timeout_pulse: got %b expected 1", timeout);
      end
      vectors++;
      if (fr_ready !== 1'b0) begin
         miscompares++; $display("FAIL timeout_ready: got %b expected 0", fr_ready);
      end
      apply(1'b1, 1'b0, 3'd0, '0);
      vectors++;
      if (timeout !== 1'b0) begin
         miscompares++; $display("FAIL timeout_pulse_width: got %b expected 0", timeout);
      end
      apply(1'b1, 1'b1, 3'd0, '0);
      for (int k = 0; k < int'(TO) - 1; k++) apply(1'b1, 1'b0, 3'd0, '0);
      apply(1'b1, 1'b0, 3'd0, 5'b00001);
      vectors++;
      if (timeout !== 1'b0 || grant !== '0) begin
         miscompares++;
         $display("FAIL timeout_release_wins: got timeout=%b grant=%b expected 0 0",
                  timeout, grant);
      end
`else
      apply(1'b1, 1'b1, 3'd0, '0);
      for (int k = 0; k < 20; k++) apply(1'b1, 1'b0, 3'd0, '0);
      vectors++;
      if (grant !== 5'b00001 || timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL no_timeout_hold: got grant=%b timeout=%b expected 00001 0",
                  grant, timeout);
      end
      apply(1'b1, 1'b0, 3'd0, 5'b00001);
`endif
   endtask

   task automatic test_random();
      logic         r;
      logic         v;
      logic [IW-1:0] idx;
      logic [W-1:0] rel;
      for (int i = 0; i < 600; i++) begin
         r   = ($urandom_range(0, 49) != 0);
         v   = ($urandom_range(0, 3) != 0);
         idx = IW'($urandom_range(0, 7));
         rel = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
         apply(r, v, idx, rel);
         vectors++;
         if (obs_ready !== exp_ready) begin
            miscompares++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready);
         end
         vectors++;
         if (grant !== exp_grant() || grant_valid !== (m_idx >= 0) ||
             grant_encoded !== ((m_idx < 0) ? IW'(0) : IW'(m_idx))) begin
            miscompares++;
            $display("FAIL rnd_grant[%0d]: got grant=%b gv=%b enc=%0d expected %b %b %0d",
                     i, grant, grant_valid, grant_encoded, exp_grant(), m_idx >= 0,
                     (m_idx < 0) ? 0 : m_idx);
         end
         vectors++;
         if (error !== m_err || timeout !== m_to) begin
            miscompares++;
            $display("FAIL rnd_pulses[%0d]: got error=%b timeout=%b expected %b %b",
                     i, error, timeout, m_err, m_to);
         end
         vectors++;
         if ($countones(grant) > 1) begin
            miscompares++; $display("FAIL rnd_onehot[%0d]: got %b expected at most one bit", i, grant);
         end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      s_valid    = 1'b0;
      s_index    = '0;
      release_in = '0;
      #1;
      test_reset();
      test_basic_grant();
      test_foreign_release();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_grant();
      test_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
